card_shoe: RTL and testbench

Sequential card source for the baccarat datapath: holds a shoe of DECKS standard decks as per-rank remaining counts, draws pseudo-random cards without replacement, and hands them to the dealing state machine over a valid/ack handshake. It is the producer of the 4-bit card codes that the hand-scoring logic consumes (1 = Ace … 10–13 = Ten/J/Q/K, 0 = no card), so drawn cards feed player/dealer card registers directly.

---
 rtl/card_pkg.sv | 35 +++
 rtl/card_lfsr16.sv | 41 ++++
 rtl/card_shoe.sv | 151 +++++++++++++++
 tb/tb_card_shoe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// card_pkg
// Shared types and constants for the card shoe and its consumers.
// Card codes: 0 = no card, 1 = Ace, 2..10 = pip cards, 11..13 = J/Q/K.
// Also holds the shoe state encoding and two small helpers used to form
// and advance the rank probe.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_NONE      = 4'd0;
  localparam card_t CARD_ACE       = 4'd1;
  localparam card_t CARD_KING      = 4'd13;
  localparam int    NUM_RANKS      = 13;
  localparam int    CARDS_PER_DECK = 52;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHUFFLE,
    ST_PICK,
    ST_OFFER
  } shoe_state_t;

  // Maps four random bits onto a starting rank 1..13 (value mod 13, plus one).
  function automatic card_t probeFromLfsr(input logic [3:0] v);
    logic [3:0] m;
    m = (v >= 4'd13) ? (v - 4'd13) : v;
    return m + 4'd1;
  endfunction

  // Steps the probe to the next rank, wrapping King back round to Ace.
  function automatic card_t nextRank(input card_t r);
    return (r == CARD_KING) ? CARD_ACE : (r + 4'd1);
  endfunction

endpackage

// File: rtl/card_lfsr16.sv
// card_lfsr16
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
// Advances on every rising clock edge once reset is released.
// Ports:
//   fast_clock  in   clock
//   resetb      in   asynchronous active-low reset, loads SEED
//   state_o     out  current 16-bit LFSR state
// Parameter SEED must be non-zero, otherwise the register locks at zero.
module card_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        fast_clock,
  input  logic        resetb,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Right-shifting Galois form: the bit shifted out of the bottom is folded
  // back into the tap positions, which for this polynomial is mask 16'hB400.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ 16'hB400;
    end
  end

  // The state register itself; it never pauses, so the draw sequence depends
  // on how many cycles have elapsed since reset, not on what the shoe is doing.
  always_ff @(posedge fast_clock or negedge resetb) begin
    if (!resetb) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/card_shoe.sv
// card_shoe
// Holds DECKS standard decks as per-rank remaining counts and draws cards
// without replacement, offering each one over a valid/ack handshake.
// Ports:
//   fast_clock  in   clock
//   resetb      in   asynchronous active-low reset
//   deal_req    in   level request for one card (looked at only when idle)
//   shuffle     in   refill the shoe (looked at only when idle, beats deal_req)
//   card_valid  out  a drawn card is being offered
//   card        out  card code 1..13, 0 when nothing is offered
//   card_ack    in   consumer takes the offered card
//   cards_left  out  cards still in the shoe
//   shoe_empty  out  no cards left
//   busy        out  machine is not idle
// Build option: define SHOE_AUTO_RESHUFFLE_EN to have a request against an
// empty shoe refill it automatically; otherwise the request waits in idle
// until an explicit shuffle.
module card_shoe
  import card_pkg::*;
#(
  parameter int          DECKS     = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       fast_clock,
  input  logic       resetb,
  input  logic       deal_req,
  input  logic       shuffle,
  output logic       card_valid,
  output logic [3:0] card,
  input  logic       card_ack,
  output logic [8:0] cards_left,
  output logic       shoe_empty,
  output logic       busy
);

  localparam logic [5:0] FULL_RANK = 6'(4 * DECKS);
  localparam logic [8:0] FULL_SHOE = 9'(CARDS_PER_DECK * DECKS);

  shoe_state_t state_q;
  logic [5:0]  rank_left_q [1:NUM_RANKS];
  logic [8:0]  cards_left_q;
  card_t       probe_q;
  card_t       card_q;
  logic        card_valid_q;
  logic        shoe_empty_q;
  logic        busy_q;

  logic [15:0] lfsrState;
  card_t       startProbe;
  logic        unusedLfsrBits;

  card_lfsr16 #(
    .SEED(LFSR_SEED)
  ) uLfsr (
    .fast_clock(fast_clock),
    .resetb    (resetb),
    .state_o   (lfsrState)
  );

  // Only the low nibble picks the first rank to try; the rest of the LFSR
  // state just keeps the sequence long.
  assign startProbe     = probeFromLfsr(lfsrState[3:0]);
  assign unusedLfsrBits = ^lfsrState[15:4];

  // Whole shoe controller in one block so every output comes straight from
  // a register. PICK walks the probe forward one rank per cycle until it
  // finds a non-empty rank; since PICK is only entered with at least one
  // card left, that search ends within 13 cycles and the counts never wrap.
  // The counts drop in the hit cycle, so cards_left already reflects the
  // drawn card while it is being offered. Reset restores a full shoe, which
  // also puts back any card that was drawn but never acknowledged.
  always_ff @(posedge fast_clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_IDLE;
      for (int r = 1; r <= NUM_RANKS; r++) begin
        rank_left_q[r] <= FULL_RANK;
      end
      cards_left_q <= FULL_SHOE;
      probe_q      <= CARD_ACE;
      card_q       <= CARD_NONE;
      card_valid_q <= 1'b0;
      shoe_empty_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (shuffle) begin
            state_q <= ST_SHUFFLE;
            busy_q  <= 1'b1;
          end else if (deal_req) begin
            if (cards_left_q != 9'd0) begin
              state_q <= ST_PICK;
              probe_q <= startProbe;
              busy_q  <= 1'b1;
            end
`ifdef SHOE_AUTO_RESHUFFLE_EN
            else begin
              state_q <= ST_SHUFFLE;
              busy_q  <= 1'b1;
            end
`endif
          end
        end

        ST_SHUFFLE: begin
          for (int r = 1; r <= NUM_RANKS; r++) begin
            rank_left_q[r] <= FULL_RANK;
          end
          cards_left_q <= FULL_SHOE;
          shoe_empty_q <= 1'b0;
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
        end

        ST_PICK: begin
          if (rank_left_q[probe_q] != 6'd0) begin
            rank_left_q[probe_q] <= rank_left_q[probe_q] - 6'd1;
            cards_left_q         <= cards_left_q - 9'd1;
            shoe_empty_q         <= (cards_left_q == 9'd1);
            card_q               <= probe_q;
            card_valid_q         <= 1'b1;
            state_q              <= ST_OFFER;
          end else begin
            probe_q <= nextRank(probe_q);
          end
        end

        ST_OFFER: begin
          if (card_ack) begin
            card_q       <= CARD_NONE;
            card_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign card_valid = card_valid_q;
  assign card       = card_q;
  assign cards_left = cards_left_q;
  assign shoe_empty = shoe_empty_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe
// Drives randomized deal requests and ack delays into card_shoe. A reference
// model of the shoe (per-rank counts plus the LFSR polynomial) predicts each
// card, its latency and the remaining count; predictions go into a queue that
// an independent monitor drains whenever the DUT raises card_valid.
module tb_card_shoe;
  import card_pkg::*;

  localparam int          DECKS = 1;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic       fast_clock = 1'b0;
  logic       resetb     = 1'b0;
  logic       deal_req   = 1'b0;
  logic       shuffle    = 1'b0;
  logic       card_ack   = 1'b0;
  logic       card_valid;
  logic [3:0] card;
  logic [8:0] cards_left;
  logic       shoe_empty;
  logic       busy;

  card_shoe #(
    .DECKS    (DECKS),
    .LFSR_SEED(SEED)
  ) dut (
    .fast_clock(fast_clock),
    .resetb    (resetb),
    .deal_req  (deal_req),
    .shuffle   (shuffle),
    .card_valid(card_valid),
    .card      (card),
    .card_ack  (card_ack),
    .cards_left(cards_left),
    .shoe_empty(shoe_empty),
    .busy      (busy)
  );

  always #5 fast_clock = ~fast_clock;

  typedef struct {
    int card;
    int latency;
    int left;
    int empty;
    int reqCyc;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [15:0] lfsrM;
  int          cnt  [1:13];
  int          seen [1:13];
  exp_t        expQ [$];

  // Cycle counter used to measure request-to-valid latency.
  always @(posedge fast_clock) cyc++;

  // Reference random source: the polynomial stepped once per clock.
  always @(posedge fast_clock or negedge resetb) begin
    if (!resetb) lfsrM <= SEED;
    else lfsrM <= {1'b0, lfsrM[15:1]} ^ (lfsrM[0] ? 16'hB400 : 16'h0000);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int modelLeft();
    int s = 0;
    for (int r = 1; r <= 13; r++) s += cnt[r];
    return s;
  endfunction

  task automatic refillModel();
    for (int r = 1; r <= 13; r++) begin
      cnt[r]  = 4 * DECKS;
      seen[r] = 0;
    end
  endtask

  // Called just before the edge at which the DUT samples deal_req in idle:
  // predicts the card from the model and raises the request.
  task automatic applyStimulus();
    exp_t e;
    int r;
    int misses = 0;
    r = (int'(lfsrM[3:0]) % 13) + 1;
    while (cnt[r] == 0 && misses < 13) begin
      r = (r == 13) ? 1 : r + 1;
      misses++;
    end
    cnt[r]--;
    e.card    = r;
    e.latency = misses + 2;
    e.left    = modelLeft();
    e.empty   = (e.left == 0) ? 1 : 0;
    e.reqCyc  = cyc;
    expQ.push_back(e);
    deal_req = 1'b1;
  endtask

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge fast_clock);
      if (card_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL valid_timeout: card_valid still 0, expected 1 within 20 cycles");
    end
  endtask

  task automatic dealOne(input int ackDelay);
    bit ok;
    @(negedge fast_clock);
    applyStimulus();
    @(posedge fast_clock);
    #1 deal_req = 1'b0;
    waitValid(ok);
    if (ok) begin
      repeat (ackDelay) @(negedge fast_clock);
      card_ack = 1'b1;
      @(posedge fast_clock);
      #1 card_ack = 1'b0;
      checkOutput("valid_after_ack", card_valid, 0);
      checkOutput("idle_after_ack", busy, 0);
    end
  endtask

  task automatic shufflePulse();
    @(negedge fast_clock);
    shuffle = 1'b1;
    @(posedge fast_clock);
    #1 shuffle = 1'b0;
    checkOutput("busy_in_shuffle", busy, 1);
    @(posedge fast_clock);
    #1;
    checkOutput("left_after_shuffle", cards_left, 52 * DECKS);
    checkOutput("empty_after_shuffle", shoe_empty, 0);
    refillModel();
  endtask

  // Monitor: pops a prediction on each rising card_valid, then watches the
  // offered card and count stay frozen until it is taken.
  logic prevValid = 1'b0;
  int   heldCard  = 0;
  int   heldLeft  = 0;
  exp_t monE;

  always @(negedge fast_clock) begin
    if (!resetb) begin
      prevValid = 1'b0;
    end else begin
      if (card_valid && !prevValid) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_card: got card %0d, expected no offer", card);
        end else begin
          monE = expQ.pop_front();
          checkOutput("card", card, monE.card);
          checkOutput("cards_left", cards_left, monE.left);
          checkOutput("shoe_empty", shoe_empty, monE.empty);
          checkOutput("latency", cyc - monE.reqCyc, monE.latency);
          if (card >= 1 && card <= 13) seen[card]++;
        end
        heldCard = card;
        heldLeft = cards_left;
      end else if (card_valid) begin
        checkOutput("card_stable", card, heldCard);
        checkOutput("left_stable", cards_left, heldLeft);
      end else begin
        checkOutput("card_zero_when_invalid", card, 0);
      end
      prevValid = card_valid;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    refillModel();
    repeat (2) @(negedge fast_clock);
    checkOutput("reset_cards_left", cards_left, 52 * DECKS);
    checkOutput("reset_card", card, 0);
    checkOutput("reset_valid", card_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_empty", shoe_empty, 0);
    resetb = 1'b1;

    // Full drain of a freshly shuffled shoe, one long ack hold included.
    shufflePulse();
    for (int i = 0; i < 52 * DECKS; i++) begin
      dealOne((i == 5) ? 20 : int'($urandom_range(0, 3)));
    end
    for (int r = 1; r <= 13; r++) checkOutput("rank_count", seen[r], 4 * DECKS);
    checkOutput("drained_empty", shoe_empty, 1);
    checkOutput("drained_left", cards_left, 0);

`ifdef SHOE_AUTO_RESHUFFLE_EN
    @(negedge fast_clock);
    deal_req = 1'b1;
    @(posedge fast_clock);
    #1 checkOutput("auto_shuffle_busy", busy, 1);
    refillModel();
    @(posedge fast_clock);
    dealOne(0);
`else
    @(negedge fast_clock);
    deal_req = 1'b1;
    repeat (100) @(negedge fast_clock);
    checkOutput("stall_valid", card_valid, 0);
    checkOutput("stall_empty", shoe_empty, 1);
    checkOutput("stall_busy", busy, 0);
    deal_req = 1'b0;
    shufflePulse();
`endif

    for (int i = 0; i < 10; i++) dealOne(int'($urandom_range(0, 2)));

    // Shuffle and request together: the refill happens first, the held
    // request is then served from the full shoe.
    @(negedge fast_clock);
    shuffle  = 1'b1;
    deal_req = 1'b1;
    @(posedge fast_clock);
    #1 shuffle = 1'b0;
    refillModel();
    @(posedge fast_clock);
    #1 checkOutput("both_left_full", cards_left, 52 * DECKS);
    dealOne(0);

    for (int i = 0; i < 3; i++) dealOne(int'($urandom_range(0, 3)));

    // Reset while a card is on offer returns it to the shoe.
    @(negedge fast_clock);
    applyStimulus();
    @(posedge fast_clock);
    #1 deal_req = 1'b0;
    waitValid(ok);
    #1 resetb = 1'b0;
    #1;
    checkOutput("midreset_valid", card_valid, 0);
    checkOutput("midreset_left", cards_left, 52 * DECKS);
    checkOutput("midreset_card", card, 0);
    checkOutput("midreset_busy", busy, 0);
    expQ.delete();
    refillModel();
    repeat (2) @(negedge fast_clock);
    resetb = 1'b1;

    for (int i = 0; i < 5; i++) dealOne(int'($urandom_range(0, 3)));

    repeat (2) @(negedge fast_clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
